cifrador_stream_core: RTL and testbench
=======================================

Name: cifrador_stream_core

Overview:
- Byte-serial stream-cipher engine that sits directly under the tt_um_cifrador_8bits pin wrapper.
- The wrapper maps ui_in/uio_in/uo_out onto this core's handshakes.
- A 16-bit key is loaded in two bytes and seeds a Galois LFSR. Each accepted byte is XORed with the LFSR low byte and rotated, then the LFSR advances one bit per cycle for STEPS_PER_BYTE cycles.
- Supports encrypt and decrypt modes, with valid/ready on both input and output.

Parameters:
LFSR_POLY  16'hB400  Galois tap mask, XORed in after a right shift when the shifted-out bit is 1
DEFAULT_SEED  16'hACE1  seed substituted for an all-zero key; also the LFSR reset value
STEPS_PER_BYTE  8  LFSR single-bit steps after each byte (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
key_valid  in  1  key byte present on key_byte
key_byte  in  8  key byte; first byte is key[7:0], second is key[15:8]
mode  in  1  0 = encrypt, 1 = decrypt; sampled on input accept
in_valid  in  1  data byte present
data_in  in  8  plaintext (mode 0) or ciphertext (mode 1)
in_ready  out  1  core accepts data this cycle
out_valid  out  1  data_out holds a result
data_out  out  8  result byte
out_ready  in  1  downstream consumes data_out
key_ok  out  1  full key loaded, core usable
busy  out  1  LFSR stepping in progress

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=KEY0, lfsr=DEFAULT_SEED, data_out=0, out_valid=0, key_ok=0, busy=0, step counter=0.
- States: KEY0, KEY1, IDLE, SHIFT.
- KEY0: on key_valid, hold key_byte as key low and go to KEY1.
- KEY1: on key_valid, form key = {key_byte, low}.
  - lfsr = key, or DEFAULT_SEED if key==0.
  - key_ok=1; go to IDLE.
- key_valid in IDLE: restart key load. Capture the byte as key low, key_ok=0, go to KEY1. key_valid wins over a simultaneous in_valid.
- key_valid in SHIFT: ignored. A pending out_valid is unaffected by rekeying.
- in_ready = (state==IDLE) && !out_valid && !key_valid, combinational.
- Accept happens when in_valid && in_ready. Let k = lfsr[7:0] at that edge.
  - Encrypt: data_out = rotl1(data_in ^ k).
  - Decrypt: data_out = rotr1(data_in) ^ k.
  - out_valid=1 at the next edge, so latency is 1 cycle.
  - Go to SHIFT; busy=1; counter=0.
- SHIFT: each cycle, lfsr = (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0) and the counter increments.
  - After exactly STEPS_PER_BYTE steps, return to IDLE with busy=0.
  - SHIFT cannot stall.
- Output: out_valid clears on the edge where out_valid && out_ready. data_out holds its value until the next accept.
- Throughput: at most one byte per STEPS_PER_BYTE+1 cycles. A later accept requires out_valid to have been cleared.
- Back-to-back: if out_ready is held high, the next accept can occur on the first IDLE cycle after SHIFT.
- in_valid while not ready: no effect. The source must hold data.
- rst mid-SHIFT or mid-key-load returns everything to reset values. The key must be reloaded.
- All arithmetic is modulo 8/16 bits. Rotates are 1-bit circular.

Test Plan:
- Key bytes 0xE1 then 0xAC (lfsr 0xACE1), mode 0, inputs 0x00, 0x00 with out_ready=1 -> outputs 0xC3 then 0x89. LFSR is 0xC2C4 after the first SHIFT. busy is high exactly 8 cycles per byte.
- Rekey to 0xACE1, mode 1, inputs 0xC3, 0x89 -> outputs 0x00, 0x00 (round trip).
- Key 0x00,0x00 -> key_ok=1 and lfsr=0xACE1. Encrypt 0x00 -> 0xC3.
- Backpressure: out_ready=0 after first result -> in_ready stays 0 after SHIFT and data_out is held at 0xC3. Raising out_ready clears out_valid and restores in_ready the next cycle.
- key_valid and in_valid together in IDLE -> data not accepted, key_ok drops, state KEY1. Before key load, in_valid=1 gives in_ready=0 and no output.
- Assert rst for 1 cycle mid-SHIFT -> out_valid=0, key_ok=0, busy=0, data_out=0, lfsr=0xACE1. Reload key 0xACE1 and encrypt 0x00 -> 0xC3.

Source files
------------

// File: rtl/cifrador_stream_core_if.sv
// ============================================================================
// Module      : cifrador_stream_core_if
// Description : Key-load, data-in and data-out handshakes of the stream cipher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cifrador_stream_core_if;
    logic       key_valid;
    logic [7:0] key_byte;
    logic       mode;
    logic       in_valid;
    logic [7:0] data_in;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] data_out;
    logic       out_ready;
    logic       key_ok;
    logic       busy;

    modport master (
        output key_valid, key_byte, mode, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, key_ok, busy
    );

    modport slave (
        input  key_valid, key_byte, mode, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, key_ok, busy
    );
endinterface

`default_nettype wire

// File: rtl/cifrador_stream_core.sv
// ============================================================================
// Module      : cifrador_stream_core
// Description : Byte-serial LFSR stream cipher with two-byte key load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cifrador_stream_core #(
    parameter logic [15:0] LFSR_POLY      = 16'hB400,
    parameter logic [15:0] DEFAULT_SEED   = 16'hACE1,
    parameter int          STEPS_PER_BYTE = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cifrador_stream_core_if.slave bus
);

    localparam logic [3:0] c_LAST_STEP = 4'(STEPS_PER_BYTE - 1);

    typedef enum logic [1:0] {
        S_KEY0  = 2'd0,
        S_KEY1  = 2'd1,
        S_IDLE  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [7:0]  r_key_lo;
    logic [7:0]  r_data_out;
    logic        r_out_valid;
    logic        r_key_ok;
    logic        r_busy;
    logic [3:0]  r_step_cnt;

    logic        w_in_ready;
    logic [15:0] w_key;
    logic [15:0] w_seed;
    logic [15:0] w_lfsr_next;
    logic [7:0]  w_k;
    logic [7:0]  w_enc_x;
    logic [7:0]  w_enc;
    logic [7:0]  w_dec;

    // Rekey request blocks data acceptance so key_valid always wins in IDLE.
    assign w_in_ready  = (r_state == S_IDLE) && !r_out_valid && !bus.key_valid;

    assign w_key       = {bus.key_byte, r_key_lo};
    assign w_seed      = (w_key == 16'h0000) ? DEFAULT_SEED : w_key;
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);

    assign w_k     = r_lfsr[7:0];
    assign w_enc_x = bus.data_in ^ w_k;
    assign w_enc   = {w_enc_x[6:0], w_enc_x[7]};
    assign w_dec   = {bus.data_in[0], bus.data_in[7:1]} ^ w_k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_KEY0;
            r_lfsr      <= DEFAULT_SEED;
            r_key_lo    <= 8'h00;
            r_data_out  <= 8'h00;
            r_out_valid <= 1'b0;
            r_key_ok    <= 1'b0;
            r_busy      <= 1'b0;
            r_step_cnt  <= 4'd0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_KEY0: begin
                    if (bus.key_valid) begin
                        r_key_lo <= bus.key_byte;
                        r_state  <= S_KEY1;
                    end
                end
                S_KEY1: begin
                    if (bus.key_valid) begin
                        r_lfsr   <= w_seed;
                        r_key_ok <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.key_valid) begin
                        r_key_lo <= bus.key_byte;
                        r_key_ok <= 1'b0;
                        r_state  <= S_KEY1;
                    end else if (bus.in_valid && w_in_ready) begin
                        r_data_out  <= bus.mode ? w_dec : w_enc;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_step_cnt  <= 4'd0;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Key bytes are ignored here; stepping never stalls.
                    r_lfsr     <= w_lfsr_next;
                    r_step_cnt <= r_step_cnt + 4'd1;
                    if (r_step_cnt == c_LAST_STEP) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_KEY0;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;
    assign bus.key_ok    = r_key_ok;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cifrador_stream_core.sv
// ============================================================================
// Module      : tb_cifrador_stream_core
// Description : Directed scoreboard bench for the byte-serial stream cipher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cifrador_stream_core;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] exp_q[$];

    cifrador_stream_core_if bus ();

    cifrador_stream_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a result is consumed when out_valid meets out_ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got 0x%0h, expected none", bus.data_out);
            end else begin
                check("data_out", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] lo, input logic [7:0] hi);
        tick();
        bus.key_valid = 1'b1;
        bus.key_byte  = lo;
        tick();
        bus.key_byte  = hi;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] din, input logic m, input logic [7:0] exp);
        bit done;
        done = 1'b0;
        exp_q.push_back(exp);
        tick();
        bus.in_valid = 1'b1;
        bus.data_in  = din;
        bus.mode     = m;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) done = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
    endtask

    task automatic count_busy(output int n);
        bit stop;
        n = 0;
        stop = 1'b0;
        for (int i = 0; i < 40 && !stop; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else stop = 1'b1;
        end
    endtask

    int nb;

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.key_valid = 1'b0;
        bus.key_byte  = 8'h00;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_key_ok", 32'(bus.key_ok), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_lfsr", 32'(dut.r_lfsr), 32'hACE1);

        // Data before any key is never accepted.
        bus.in_valid = 1'b1;
        bus.data_in  = 8'h5A;
        #1 check("nokey_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) tick();
        check("nokey_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;

        // Encrypt two zero bytes under key 0xACE1.
        load_key(8'hE1, 8'hAC);
        check("key_ok", 32'(bus.key_ok), 32'd1);
        check("lfsr_seed", 32'(dut.r_lfsr), 32'hACE1);
        send(8'h00, 1'b0, 8'hC3);
        count_busy(nb);
        check("busy_cycles_1", 32'(nb), 32'd8);
        check("lfsr_after_shift", 32'(dut.r_lfsr), 32'hC2C4);
        send(8'h00, 1'b0, 8'h89);
        count_busy(nb);
        check("busy_cycles_2", 32'(nb), 32'd8);

        // Decrypt round trip.
        load_key(8'hE1, 8'hAC);
        send(8'hC3, 1'b1, 8'h00);
        count_busy(nb);
        send(8'h89, 1'b1, 8'h00);
        count_busy(nb);

        // All-zero key falls back to the default seed.
        load_key(8'h00, 8'h00);
        check("zero_key_ok", 32'(bus.key_ok), 32'd1);
        check("zero_key_lfsr", 32'(dut.r_lfsr), 32'hACE1);
        send(8'h00, 1'b0, 8'hC3);
        count_busy(nb);

        // Backpressure holds the result and blocks the next accept.
        load_key(8'hE1, 8'hAC);
        bus.out_ready = 1'b0;
        send(8'h00, 1'b0, 8'hC3);
        count_busy(nb);
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.data_in  = 8'h11;
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_data_out", 32'(bus.data_out), 32'hC3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

        // key_valid wins over in_valid in IDLE.
        tick();
        bus.key_valid = 1'b1;
        bus.key_byte  = 8'hE1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 8'h55;
        #1 check("collide_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("collide_key_ok", 32'(bus.key_ok), 32'd0);
        check("collide_state", 32'(dut.r_state), 32'd1);
        check("collide_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        bus.key_byte = 8'hAC;
        tick();
        bus.key_valid = 1'b0;
        check("collide_rekey_ok", 32'(bus.key_ok), 32'd1);

        // Reset mid-SHIFT clears everything.
        send(8'h00, 1'b0, 8'hC3);
        repeat (3) tick();
        check("mid_shift_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_key_ok", 32'(bus.key_ok), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_data_out", 32'(bus.data_out), 32'h00);
        check("post_rst_lfsr", 32'(dut.r_lfsr), 32'hACE1);
        load_key(8'hE1, 8'hAC);
        send(8'h00, 1'b0, 8'hC3);
        count_busy(nb);
        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
